// File: rtl/led_pattern_sched_if.sv
// Signal bundle between the board-input side and the LED sequencer.
// The master drives the key, pause and speed controls and receives the display outputs.
interface led_pattern_sched_if #(
    parameter int unsigned LED_W = 4
);
    logic             mode_key;
    logic             pause;
    logic [1:0]       speed;
    logic [LED_W-1:0] led_out;
    logic [2:0]       mode;
    logic             step_tick;

    modport master (
        output mode_key, pause, speed,
        input  led_out, mode, step_tick
    );

    modport slave (
        input  mode_key, pause, speed,
        output led_out, mode, step_tick
    );
endinterface

// File: rtl/led_pattern_sched.sv
// LED bank sequencer: prescaled step tick, five display modes, mode key and pause.
// Define LED_DEBOUNCE_EN to treat mode_key as a raw button (synchronizer + debouncer).
module led_pattern_sched #(
    parameter int unsigned LED_W      = 4,
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input logic                 clk,
    input logic                 rst_n,
    led_pattern_sched_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV * 8);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLOW_L   = 3'd1,
        FLOW_R   = 3'd2,
        PINGPONG = 3'd3,
        BLINK    = 3'd4
    } mode_e;

    if (LED_W < 2 || TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_param_check
        $error("led_pattern_sched: illegal parameter value");
    end

    mode_e            state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] term_cnt;
    logic             dir_q, dir_d;     // 0 = moving toward bit LED_W-1
    logic             tick_q, tick_d;
    logic [1:0]       speed_q;
    logic             key_adv;

    function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
        logic [LED_W-1:0] p;
        p = '0;
        case (m)
            FLOW_L:   p[0] = 1'b1;
            FLOW_R:   p[LED_W-1] = 1'b1;
            PINGPONG: p[0] = 1'b1;
            BLINK:    p = '1;
            default:  p = '0;
        endcase
        return p;
    endfunction

`ifdef LED_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic             sync1, sync2, deb_lvl, adv_q;
    logic [DEB_W-1:0] deb_cnt;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
            adv_q   <= 1'b0;
        end else begin
            sync1 <= bus.mode_key;
            sync2 <= sync1;
            adv_q <= 1'b0;
            if (sync2 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb_lvl <= sync2;
                deb_cnt <= '0;
                adv_q   <= sync2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign key_adv = adv_q;
`else
    assign key_adv = bus.mode_key;
`endif

    always_comb term_cnt = CNT_W'((TICK_DIV << bus.speed) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            led_q   <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            speed_q <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            speed_q <= bus.speed;
        end
    end

    // Priority: key advance (discards a coincident step), then pause, then speed change.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        if (key_adv) begin
            case (state_q)
                IDLE:     state_d = FLOW_L;
                FLOW_L:   state_d = FLOW_R;
                FLOW_R:   state_d = PINGPONG;
                PINGPONG: state_d = BLINK;
                default:  state_d = IDLE;
            endcase
            led_d   = init_pattern(state_d);
            presc_d = '0;
            dir_d   = 1'b0;
        end else if (!bus.pause) begin
            if (bus.speed != speed_q) begin
                presc_d = '0;
            end else if (presc_q == term_cnt) begin
                presc_d = '0;
                tick_d  = 1'b1;
                case (state_q)
                    FLOW_L:   led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    FLOW_R:   led_d = {led_q[0], led_q[LED_W-1:1]};
                    PINGPONG: begin
                        if (!dir_q) begin
                            led_d = led_q << 1;
                            if (led_d[LED_W-1]) dir_d = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                            if (led_d[0]) dir_d = 1'b0;
                        end
                    end
                    BLINK:    led_d = ~led_q;
                    default:  led_d = '0;
                endcase
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign bus.led_out   = led_q;
    assign bus.mode      = state_q;
    assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched (LED_W=4, TICK_DIV=5, DEB_CYCLES=8).
// Expected LED patterns are queued per scenario and popped on each step_tick.
module tb_led_pattern_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_q[$];

    led_pattern_sched_if #(.LED_W(4)) bus();

    led_pattern_sched #(.LED_W(4), .TICK_DIV(5), .DEB_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got no_finish want finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.mode == 3'd1 || bus.mode == 3'd2 || bus.mode == 3'd3)) begin
            checks++;
            if ($countones(bus.led_out) !== 1) begin
                errors++;
                $display("FAIL one_hot mode=%0d led=%b want exactly one bit", bus.mode, bus.led_out);
            end
        end
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.step_tick !== 1'b1 && n < 200);
    endtask

    task automatic key_pulse();
        bus.mode_key = 1'b1;
        @(negedge clk);
        bus.mode_key = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mode_key = 1'b0;
        bus.pause = 1'b0;
        bus.speed = 2'd0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.led_out !== 4'b0000 || bus.mode !== 3'd0 || bus.step_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got led=%b mode=%0d tick=%b want 0000/0/0",
                     bus.led_out, bus.mode, bus.step_tick);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            checks++;
            if (bus.led_out !== 4'b0000 || bus.mode !== 3'd0 ||
                bus.step_tick !== ((i % 5) == 0)) begin
                errors++;
                $display("FAIL idle_cycle%0d got led=%b mode=%0d tick=%b want 0000/0/%0d",
                         i, bus.led_out, bus.mode, bus.step_tick, (i % 5) == 0);
            end
        end
    endtask

    task automatic test_flow_l();
        int n;
        logic [3:0] e;
        key_pulse();
        checks++;
        if (bus.mode !== 3'd1 || bus.led_out !== 4'b0001 || bus.step_tick !== 1'b0) begin
            errors++;
            $display("FAIL flow_l_enter got mode=%0d led=%b tick=%b want 1/0001/0",
                     bus.mode, bus.led_out, bus.step_tick);
        end
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        while (exp_q.size() > 0) begin
            wait_tick(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== 5) begin
                errors++;
                $display("FAIL flow_l_interval got %0d want 5", n);
            end
            checks++;
            if (bus.led_out !== e) begin
                errors++;
                $display("FAIL flow_l_led got %b want %b", bus.led_out, e);
            end
        end
    endtask

    task automatic test_speed();
        int n;
        int per[$];
        logic [3:0] e;
        bus.speed = 2'd2;
        @(negedge clk);
        exp_q.push_back(4'b0010); per.push_back(20);
        exp_q.push_back(4'b0100); per.push_back(20);
        while (exp_q.size() > 0) begin
            wait_tick(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== per[0]) begin
                errors++;
                $display("FAIL speed2_interval got %0d want %0d", n, per[0]);
            end
            void'(per.pop_front());
            checks++;
            if (bus.led_out !== e) begin
                errors++;
                $display("FAIL speed2_led got %b want %b", bus.led_out, e);
            end
        end
        repeat (7) @(negedge clk);
        bus.speed = 2'd1;
        @(negedge clk);
        wait_tick(n);
        checks++;
        if (n !== 10 || bus.led_out !== 4'b1000) begin
            errors++;
            $display("FAIL speed_midchange got interval=%0d led=%b want 10/1000", n, bus.led_out);
        end
        bus.speed = 2'd0;
        @(negedge clk);
        wait_tick(n);
        checks++;
        if (n !== 5 || bus.led_out !== 4'b0001) begin
            errors++;
            $display("FAIL speed_back0 got interval=%0d led=%b want 5/0001", n, bus.led_out);
        end
    endtask

    task automatic test_patterns();
        int n;
        logic [3:0] e;
        logic [2:0] m;
        logic [3:0] init_led [3] = '{4'b1000, 4'b0001, 4'b1111};
        for (int s = 0; s < 3; s++) begin
            key_pulse();
            m = 3'(s + 2);
            checks++;
            if (bus.mode !== m || bus.led_out !== init_led[s]) begin
                errors++;
                $display("FAIL mode%0d_enter got mode=%0d led=%b want %0d/%b",
                         m, bus.mode, bus.led_out, m, init_led[s]);
            end
            case (s)
                0: begin
                    exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
                    exp_q.push_back(4'b0001); exp_q.push_back(4'b1000);
                end
                1: begin
                    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
                    exp_q.push_back(4'b1000); exp_q.push_back(4'b0100);
                    exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
                    exp_q.push_back(4'b0010);
                end
                default: begin
                    exp_q.push_back(4'b0000); exp_q.push_back(4'b1111);
                end
            endcase
            while (exp_q.size() > 0) begin
                wait_tick(n);
                e = exp_q.pop_front();
                checks++;
                if (n !== 5 || bus.led_out !== e) begin
                    errors++;
                    $display("FAIL mode%0d_step got interval=%0d led=%b want 5/%b",
                             m, n, bus.led_out, e);
                end
            end
        end
    endtask

    task automatic test_pause();
        int n;
        bus.pause = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (bus.led_out !== 4'b1111 || bus.step_tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold cyc%0d got led=%b tick=%b want 1111/0",
                         i, bus.led_out, bus.step_tick);
            end
        end
        key_pulse();
        checks++;
        if (bus.mode !== 3'd0 || bus.led_out !== 4'b0000) begin
            errors++;
            $display("FAIL pause_key_idle got mode=%0d led=%b want 0/0000", bus.mode, bus.led_out);
        end
        key_pulse();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mode !== 3'd1 || bus.led_out !== 4'b0001 || bus.step_tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_key_flow got mode=%0d led=%b tick=%b want 1/0001/0",
                         bus.mode, bus.led_out, bus.step_tick);
            end
        end
        bus.pause = 1'b0;
        wait_tick(n);
        checks++;
        if (n !== 5 || bus.led_out !== 4'b0010) begin
            errors++;
            $display("FAIL pause_resume got interval=%0d led=%b want 5/0010", n, bus.led_out);
        end
        repeat (4) @(negedge clk);
        key_pulse();
        checks++;
        if (bus.mode !== 3'd2 || bus.led_out !== 4'b1000 || bus.step_tick !== 1'b0) begin
            errors++;
            $display("FAIL key_on_terminal got mode=%0d led=%b tick=%b want 2/1000/0",
                     bus.mode, bus.led_out, bus.step_tick);
        end
        wait_tick(n);
        checks++;
        if (n !== 5 || bus.led_out !== 4'b0100) begin
            errors++;
            $display("FAIL after_terminal got interval=%0d led=%b want 5/0100", n, bus.led_out);
        end
    endtask

    task automatic test_async_reset();
        key_pulse();
        key_pulse();
        checks++;
        if (bus.mode !== 3'd4 || bus.led_out !== 4'b1111) begin
            errors++;
            $display("FAIL pre_reset_blink got mode=%0d led=%b want 4/1111", bus.mode, bus.led_out);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.led_out !== 4'b0000 || bus.mode !== 3'd0 || bus.step_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got led=%b mode=%0d tick=%b want 0000/0/0",
                     bus.led_out, bus.mode, bus.step_tick);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n;
        bus.mode_key = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mode !== 3'd1 || bus.led_out !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_first got mode=%0d led=%b want 1/0001", bus.mode, bus.led_out);
        end
        @(negedge clk);
        bus.mode_key = 1'b0;
        checks++;
        if (bus.mode !== 3'd2 || bus.led_out !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_second got mode=%0d led=%b want 2/1000", bus.mode, bus.led_out);
        end
        wait_tick(n);
        checks++;
        if (n !== 5 || bus.led_out !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_step got interval=%0d led=%b want 5/0100", n, bus.led_out);
        end
    endtask

`ifdef LED_DEBOUNCE_EN
    task automatic test_debounce();
        bus.mode_key = 1'b1;
        repeat (3) @(negedge clk);
        bus.mode_key = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (bus.mode !== 3'd0) begin
            errors++;
            $display("FAIL deb_glitch got mode=%0d want 0", bus.mode);
        end
        bus.mode_key = 1'b1;
        repeat (20) @(negedge clk);
        bus.mode_key = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (bus.mode !== 3'd1 || bus.led_out === 4'b0000) begin
            errors++;
            $display("FAIL deb_press got mode=%0d led=%b want 1/nonzero", bus.mode, bus.led_out);
        end
    endtask
`endif

    initial begin
        bus.mode_key = 1'b0;
        bus.pause = 1'b0;
        bus.speed = 2'd0;
        test_reset();
`ifdef LED_DEBOUNCE_EN
        test_debounce();
`else
        test_flow_l();
        test_speed();
        test_patterns();
        test_pause();
        test_async_reset();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
